mem_arbiter: RTL and testbench

Shares the single backing-memory port between the instruction-cache line refill engine and the data-memory (Memory stage) load/store path. Sequences multi-beat I-cache refills with a beat counter and single-beat D accesses. Arbitrates round-robin on simultaneous requests. Produces per-requester completion strobes and a data-side stall that the hazard logic ORs into the pipeline stall set.

---
 rtl/mem_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single backing-memory port between the I-cache
// refill engine (multi-beat line fills) and the Memory-stage load/store path
// (single beats). Simultaneous requests are granted round-robin; at most one
// memory beat is outstanding at any time.
// Optional build macro: CRIT_WORD_FIRST_EN -- refills start at the missed
// word and wrap around the line instead of always starting at word 0.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ICReq,
  input  logic [ADDR_WIDTH-1:0]           ICAddr,
  output logic [DATA_WIDTH-1:0]           ICRData,
  output logic                            ICRValid,
  output logic [$clog2(BLOCK_WORDS)-1:0]  ICBeatIdx,
  output logic                            ICDone,
  input  logic                            DReq,
  input  logic                            DWE,
  input  logic [ADDR_WIDTH-1:0]           DAddr,
  input  logic [DATA_WIDTH-1:0]           DWData,
  output logic [DATA_WIDTH-1:0]           DRData,
  output logic                            DDone,
  output logic                            StallMemD,
  output logic                            MemValid,
  output logic                            MemWE,
  output logic [ADDR_WIDTH-1:0]           MemAddr,
  output logic [DATA_WIDTH-1:0]           MemWData,
  input  logic                            MemReady,
  input  logic                            MemRValid,
  input  logic [DATA_WIDTH-1:0]           MemRData
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = IDX_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    I_ISSUE,
    I_WAIT,
    D_ISSUE,
    D_WAIT
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           beat_q, beat_d;
  logic [IDX_W-1:0]           start_q, start_d;
  logic [ADDR_WIDTH-1:OFF_W]  lineTag_q, lineTag_d;
  logic [ADDR_WIDTH-1:0]      dAddr_q, dAddr_d;
  logic [DATA_WIDTH-1:0]      dWData_q, dWData_d;
  logic                       dWE_q, dWE_d;
  logic                       lastGrantD_q, lastGrantD_d;
  logic                       icRValid_q, icRValid_d;
  logic [DATA_WIDTH-1:0]      icRData_q, icRData_d;
  logic [IDX_W-1:0]           icBeatIdx_q, icBeatIdx_d;
  logic                       icDone_q, icDone_d;
  logic                       dDone_q, dDone_d;
  logic [DATA_WIDTH-1:0]      dRData_q, dRData_d;

  logic                       reqI, reqD;
  logic                       grantI, grantD;
  logic [IDX_W-1:0]           reqStart;
  logic [IDX_W-1:0]           beatNext;
  logic                       lastBeat;
  logic [ADDR_WIDTH-1:0]      beatAddr;
  logic                       unusedIcOffset;

`ifdef CRIT_WORD_FIRST_EN
  assign reqStart = ICAddr[OFF_W-1:2];
`else
  assign reqStart = '0;
`endif

  // The byte offset of ICAddr only matters for the start word, if at all.
  assign unusedIcOffset = ^ICAddr[OFF_W-1:0];

  // A requester whose Done is showing this cycle is finished even if its
  // request line has not dropped yet, so it must not be re-granted.
  assign reqI   = ICReq & ~icDone_q;
  assign reqD   = DReq & ~dDone_q;
  assign grantI = reqI & (~reqD | lastGrantD_q);
  assign grantD = reqD & (~reqI | ~lastGrantD_q);

  // The beat after the final one would be the start word again.
  assign beatNext = beat_q + IDX_W'(1);
  assign lastBeat = (beatNext == start_q);
  assign beatAddr = {lineTag_q, beat_q, 2'b00};

  assign ICRData   = icRData_q;
  assign ICRValid  = icRValid_q;
  assign ICBeatIdx = icBeatIdx_q;
  assign ICDone    = icDone_q;
  assign DRData    = dRData_q;
  assign DDone     = dDone_q;
  assign StallMemD = DReq & ~dDone_q;

  // Memory request port decoded from the state; values are latched copies so
  // they stay stable until the beat is accepted.
  always_comb begin
    MemValid = 1'b0;
    MemWE    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    case (state_q)
      I_ISSUE: begin
        MemValid = 1'b1;
        MemAddr  = beatAddr;
      end
      D_ISSUE: begin
        MemValid = 1'b1;
        MemWE    = dWE_q;
        MemAddr  = dAddr_q;
        MemWData = dWData_q;
      end
      default: ;
    endcase
  end

  // Next-state logic: arbitration, beat sequencing and completion strobes.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    start_d      = start_q;
    lineTag_d    = lineTag_q;
    dAddr_d      = dAddr_q;
    dWData_d     = dWData_q;
    dWE_d        = dWE_q;
    lastGrantD_d = lastGrantD_q;
    icRValid_d   = 1'b0;
    icRData_d    = icRData_q;
    icBeatIdx_d  = icBeatIdx_q;
    icDone_d     = 1'b0;
    dDone_d      = 1'b0;
    dRData_d     = dRData_q;
    case (state_q)
      IDLE: begin
        if (grantI) begin
          state_d      = I_ISSUE;
          lineTag_d    = ICAddr[ADDR_WIDTH-1:OFF_W];
          start_d      = reqStart;
          beat_d       = reqStart;
          lastGrantD_d = 1'b0;
        end else if (grantD) begin
          state_d      = D_ISSUE;
          dAddr_d      = DAddr;
          dWData_d     = DWData;
          dWE_d        = DWE;
          lastGrantD_d = 1'b1;
        end
      end
      I_ISSUE: begin
        if (MemReady) begin
          state_d = I_WAIT;
        end
      end
      I_WAIT: begin
        if (MemRValid) begin
          icRValid_d  = 1'b1;
          icRData_d   = MemRData;
          icBeatIdx_d = beat_q;
          if (lastBeat) begin
            icDone_d = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_d  = beatNext;
            state_d = I_ISSUE;
          end
        end
      end
      D_ISSUE: begin
        if (MemReady) begin
          if (dWE_q) begin
            dDone_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = D_WAIT;
          end
        end
      end
      D_WAIT: begin
        if (MemRValid) begin
          dRData_d = MemRData;
          dDone_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      start_q      <= '0;
      lineTag_q    <= '0;
      dAddr_q      <= '0;
      dWData_q     <= '0;
      dWE_q        <= 1'b0;
      lastGrantD_q <= 1'b0;
      icRValid_q   <= 1'b0;
      icRData_q    <= '0;
      icBeatIdx_q  <= '0;
      icDone_q     <= 1'b0;
      dDone_q      <= 1'b0;
      dRData_q     <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      start_q      <= start_d;
      lineTag_q    <= lineTag_d;
      dAddr_q      <= dAddr_d;
      dWData_q     <= dWData_d;
      dWE_q        <= dWE_d;
      lastGrantD_q <= lastGrantD_d;
      icRValid_q   <= icRValid_d;
      icRData_q    <= icRData_d;
      icBeatIdx_q  <= icBeatIdx_d;
      icDone_q     <= icDone_d;
      dDone_q      <= dDone_d;
      dRData_q     <= dRData_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter as both requesters and as the backing
// memory, and keeps a transaction-level model of who owns the port, which
// beat is next and when each completion strobe must appear.
module tb_mem_arbiter;

  localparam int BW = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = $clog2(BW);
`ifdef CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ICReq;
  logic [AW-1:0] ICAddr;
  logic [DW-1:0] ICRData;
  logic          ICRValid;
  logic [IW-1:0] ICBeatIdx;
  logic          ICDone;
  logic          DReq;
  logic          DWE;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWData;
  logic [DW-1:0] DRData;
  logic          DDone;
  logic          StallMemD;
  logic          MemValid;
  logic          MemWE;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic          MemReady;
  logic          MemRValid;
  logic [DW-1:0] MemRData;

  always #5 clk = ~clk;

  mem_arbiter #(.BLOCK_WORDS(BW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ICReq(ICReq), .ICAddr(ICAddr), .ICRData(ICRData), .ICRValid(ICRValid),
    .ICBeatIdx(ICBeatIdx), .ICDone(ICDone),
    .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DWData(DWData),
    .DRData(DRData), .DDone(DDone), .StallMemD(StallMemD),
    .MemValid(MemValid), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemReady(MemReady), .MemRValid(MemRValid), .MemRData(MemRData)
  );

  int compared = 0;
  int mismatched = 0;

  // transaction model: owner 0 = nobody, 1 = I refill, 2 = D access
  int          owner;
  bit          issuing;
  bit          lastGrantD;
  int          k;
  int          startIdx;
  logic [31:0] lineBase, dAddrM, dWDataM;
  bit          dWEM;
  int          rdCountdown;
  logic [31:0] rdAddr;

  // what the DUT must show at the next sampling point
  bit          expMemValid, expMemWE, expIcValid, expIcDone, expDDone, expDLoad;
  logic [31:0] expMemAddr, expMemWData, expIcData, expIcIdx, expDRData;

  // stimulus knobs and directed requests
  bit          randomMode;
  int          readyPct, latMin, latMax, readyHold;
  bit          wantI, wantD, wantDWE;
  logic [31:0] wantIAddr, wantDAddr, wantDWData;

  // observations used by the literal checks
  int          cyc, raiseCycI, raiseCycD, doneCycI, accCyc, dDoneCyc;
  int          icBeatsObs, dDoneObs;
  logic [31:0] doneIdxObs, dRDataObs;
  logic [31:0] accQ[$];
  logic        accWEQ[$];
  logic [31:0] accWDataQ[$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] beatAddrM();
    return lineBase + 32'(((startIdx + k) % BW) * 4);
  endfunction

  function automatic logic [31:0] accAt(input int i);
    if (i < accQ.size()) return accQ[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic accWEAt(input int i);
    if (i < accWEQ.size()) return accWEQ[i];
    return 1'bx;
  endfunction

  function automatic logic [31:0] accWDAt(input int i);
    if (i < accWDataQ.size()) return accWDataQ[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic modelReset();
    owner = 0; issuing = 0; lastGrantD = 0; k = 0; startIdx = 0;
    rdCountdown = -1;
    expMemValid = 0; expMemWE = 0; expIcValid = 0; expIcDone = 0;
    expDDone = 0; expDLoad = 0;
    expMemAddr = 0; expMemWData = 0; expIcData = 0; expIcIdx = 0; expDRData = 0;
    wantI = 0; wantD = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, " MemValid"}, MemValid, 0);
    checkVal({tag, " MemWE"}, MemWE, 0);
    checkVal({tag, " MemAddr"}, MemAddr, 0);
    checkVal({tag, " MemWData"}, MemWData, 0);
    checkVal({tag, " ICRValid"}, ICRValid, 0);
    checkVal({tag, " ICDone"}, ICDone, 0);
    checkVal({tag, " ICRData"}, ICRData, 0);
    checkVal({tag, " ICBeatIdx"}, 32'(ICBeatIdx), 0);
    checkVal({tag, " DDone"}, DDone, 0);
    checkVal({tag, " DRData"}, DRData, 0);
  endtask

  // compare every DUT output against what the model predicted for this cycle
  task automatic checkOutput();
    checkVal("StallMemD", StallMemD, 32'(DReq & ~expDDone));
    checkVal("MemValid", MemValid, 32'(expMemValid));
    if (expMemValid) begin
      checkVal("MemAddr", MemAddr, expMemAddr);
      checkVal("MemWE", MemWE, 32'(expMemWE));
      if (expMemWE) checkVal("MemWData", MemWData, expMemWData);
    end
    checkVal("ICRValid", ICRValid, 32'(expIcValid));
    checkVal("ICDone", ICDone, 32'(expIcDone));
    if (expIcValid) begin
      checkVal("ICRData", ICRData, expIcData);
      checkVal("ICBeatIdx", 32'(ICBeatIdx), expIcIdx);
    end
    checkVal("DDone", DDone, 32'(expDDone));
    if (expDDone && expDLoad) checkVal("DRData", DRData, expDRData);
    if (ICRValid) icBeatsObs++;
    if (ICDone) begin doneCycI = cyc; doneIdxObs = 32'(ICBeatIdx); end
    if (DDone) begin dDoneObs++; dDoneCyc = cyc; dRDataObs = DRData; end
  endtask

  // drive requesters and memory for the next edge and advance the model
  task automatic applyStimulus();
    bit dropI, dropD, rv, takeI;
    dropI = expIcDone;
    dropD = expDDone;
    if (dropI) ICReq = 1'b0;
    if (dropD) DReq = 1'b0;
    if (randomMode) begin
      if (!ICReq && !dropI && $urandom_range(0, 7) == 0) begin
        wantI = 1; wantIAddr = $urandom;
      end
      if (!DReq && !dropD && $urandom_range(0, 5) == 0) begin
        wantD = 1; wantDAddr = $urandom & 32'hFFFF_FFFC;
        wantDWE = 1'($urandom_range(0, 1)); wantDWData = $urandom;
      end
    end
    if (wantI && !ICReq && !dropI) begin
      ICReq = 1'b1; ICAddr = wantIAddr; wantI = 0; raiseCycI = cyc;
    end
    if (wantD && !DReq && !dropD) begin
      DReq = 1'b1; DAddr = wantDAddr; DWE = wantDWE; DWData = wantDWData;
      wantD = 0; raiseCycD = cyc;
    end

    rv = 0;
    if (rdCountdown > 0) begin
      rdCountdown--;
      if (rdCountdown == 0) begin rv = 1; rdCountdown = -1; end
    end
    MemRValid = rv;
    MemRData  = rv ? memData(rdAddr) : $urandom;
    if (expMemValid && readyHold > 0) begin
      MemReady = 1'b0; readyHold--;
    end else begin
      MemReady = ($urandom_range(1, 100) <= readyPct);
    end

    expIcValid = 0; expIcDone = 0; expDDone = 0; expDLoad = 0;
    if (owner == 0) begin
      if (ICReq || DReq) begin
        takeI = ICReq && (!DReq || lastGrantD);
        if (takeI) begin
          owner = 1; lastGrantD = 0; k = 0;
          lineBase = ICAddr & ~32'(BW * 4 - 1);
          startIdx = CWF ? int'((ICAddr / 4) % BW) : 0;
        end else begin
          owner = 2; lastGrantD = 1;
          dAddrM = DAddr; dWDataM = DWData; dWEM = DWE;
        end
        issuing = 1;
      end
    end else if (issuing) begin
      if (MemReady) begin
        accQ.push_back(MemAddr); accWEQ.push_back(MemWE);
        accWDataQ.push_back(MemWData); accCyc = cyc;
        if (owner == 2 && dWEM) begin
          expDDone = 1; owner = 0;
        end else begin
          issuing = 0;
          rdAddr = (owner == 1) ? beatAddrM() : dAddrM;
          rdCountdown = $urandom_range(latMin, latMax);
        end
      end
    end else if (rv) begin
      if (owner == 1) begin
        expIcValid = 1; expIcData = MemRData;
        expIcIdx = 32'((startIdx + k) % BW);
        k++;
        if (k == BW) begin expIcDone = 1; owner = 0; end
        else issuing = 1;
      end else begin
        expDDone = 1; expDLoad = 1; expDRData = MemRData; owner = 0;
      end
    end
    expMemValid = (owner != 0) && issuing;
    expMemAddr  = (owner == 1) ? beatAddrM() : dAddrM;
    expMemWE    = (owner == 2) && dWEM;
    expMemWData = dWDataM;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    checkOutput();
    applyStimulus();
  endtask

  task automatic runUntilIdle(input int budget, input string name);
    int n;
    n = 0;
    while (!(owner == 0 && !ICReq && !DReq && !wantI && !wantD) && n < budget) begin
      stepCycle();
      n++;
    end
    compared++;
    if (n >= budget) begin
      mismatched++;
      $display("[TB] FAIL %s timeout: still busy after %0d cycles, expected idle", name, n);
    end
  endtask

  task automatic requestI(input logic [31:0] a);
    wantI = 1; wantIAddr = a;
  endtask

  task automatic requestD(input bit we, input logic [31:0] a, input logic [31:0] d);
    wantD = 1; wantDWE = we; wantDAddr = a; wantDWData = d;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    ICReq = 0; ICAddr = 0; DReq = 0; DWE = 0; DAddr = 0; DWData = 0;
    MemReady = 0; MemRValid = 0; MemRData = 0;
    randomMode = 0; readyPct = 100; latMin = 1; latMax = 1; readyHold = 0;
    cyc = 0; icBeatsObs = 0; dDoneObs = 0;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset_n = 1'b1;

    // simultaneous requests straight after reset: D wins, then the refill
    accQ.delete();
    requestI(32'h0000_4000);
    requestD(1'b0, 32'h0000_5008, 32'h0);
    runUntilIdle(200, "sim1");
    checkVal("sim1 first grant", accAt(0), 32'h0000_5008);
    checkVal("sim1 refill first beat", accAt(1), 32'h0000_4000);
    checkVal("sim1 beat count", accQ.size(), 1 + BW);

    // zero-wait refill of the line holding 0x1044
    accQ.delete(); icBeatsObs = 0;
    requestI(32'h0000_1044);
    runUntilIdle(200, "refill");
    checkVal("refill first addr", accAt(0), CWF ? 32'h0000_1044 : 32'h0000_1040);
    checkVal("refill 16th addr", accAt(15), CWF ? 32'h0000_1040 : 32'h0000_107C);
    checkVal("refill done idx", doneIdxObs, CWF ? 32'd0 : 32'd15);
    checkVal("refill beats", icBeatsObs, 16);
    checkVal("refill latency", doneCycI - raiseCycI, 33);

    // load with a stalled memory port and two cycles of read latency
    accQ.delete(); dDoneObs = 0;
    readyHold = 3; latMin = 2; latMax = 2;
    requestD(1'b0, 32'h0000_2000, 32'h1111_1111);
    runUntilIdle(100, "load");
    checkVal("load DRData", dRDataObs, 32'hDEAD_BEEF);
    checkVal("load DDone count", dDoneObs, 1);
    checkVal("load accept delay", accCyc - raiseCycD, 4);
    checkVal("load done delay", dDoneCyc - accCyc, 3);

    // store completes one cycle after acceptance
    accQ.delete(); accWEQ.delete(); accWDataQ.delete(); dDoneObs = 0;
    latMin = 1; latMax = 1;
    requestD(1'b1, 32'h0000_3000, 32'h1234_5678);
    runUntilIdle(100, "store");
    checkVal("store addr", accAt(0), 32'h0000_3000);
    checkVal("store we", 32'(accWEAt(0)), 1);
    checkVal("store data", accWDAt(0), 32'h1234_5678);
    checkVal("store done delay", dDoneCyc - accCyc, 1);
    checkVal("store DDone count", dDoneObs, 1);

    // D was granted last, so a simultaneous pair now starts with the refill
    accQ.delete();
    requestI(32'h0000_6000);
    requestD(1'b0, 32'h0000_700C, 32'h0);
    runUntilIdle(200, "sim2");
    checkVal("sim2 first grant", accAt(0), 32'h0000_6000);
    checkVal("sim2 D after refill", accAt(BW), 32'h0000_700C);

    // randomized traffic with random ready and read latency
    randomMode = 1; readyPct = 70; latMin = 1; latMax = 4;
    repeat (1500) stepCycle();
    randomMode = 0;
    runUntilIdle(400, "random drain");

    // reset while beat 5 of a refill is outstanding
    readyPct = 100; latMin = 3; latMax = 3;
    requestI(32'h0000_8000);
    n = 0;
    while (!(owner == 1 && k == 5 && !issuing) && n < 100) begin
      stepCycle();
      n++;
    end
    checkVal("reach beat 5", 32'(n < 100), 1);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs("midreset");
    ICReq = 0; DReq = 0; MemReady = 0; MemRValid = 0;
    modelReset();
    @(negedge clk);
    cyc++;
    reset_n = 1'b1;
    MemRValid = 1'b1;
    MemRData = 32'hBAD0_BAD0;
    stepCycle();
    checkVal("stray rvalid ignored", ICRValid, 0);
    accQ.delete(); icBeatsObs = 0;
    latMin = 1; latMax = 1;
    requestI(32'h0000_8000);
    runUntilIdle(200, "restart");
    checkVal("restart first addr", accAt(0), 32'h0000_8000);
    checkVal("restart beats", icBeatsObs, 16);

    repeat (2) stepCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
